// File: rtl/uart_rx.sv
// 8N1 serial receiver: line synchronizer, fractional oversampling tick, framing FSM
// and a small show-ahead FIFO polled by the CPU-side I/O decode.
module uart_rx #(
  parameter int unsigned ClkFrequency = 1_000_000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 8,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  input  logic                         rd_en,
  output logic [7:0]                   rx_data,
  output logic                         rx_avail,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int unsigned     AccW       = $clog2(ClkFrequency / (Baud * Oversampling)) + 8;
  localparam int unsigned     SumW       = AccW + 1;
  localparam longint unsigned SampleRate = 64'(Baud) * 64'(Oversampling);
  localparam longint unsigned IncFull    = ((SampleRate << AccW) + 64'(ClkFrequency / 2))
                                           / 64'(ClkFrequency);
  localparam logic [SumW-1:0] Inc        = SumW'(IncFull);

  localparam int unsigned      ScntW   = $clog2(Oversampling);
  localparam logic [ScntW-1:0] MidCnt  = ScntW'(Oversampling / 2 - 1);
  localparam logic [ScntW-1:0] LastCnt = ScntW'(Oversampling - 1);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  // Two-flop synchronizer; primed masks the reset value of the flops, which is not
  // a real observation of the line, so a low line across reset release is not seen as idle.
  logic [1:0] sync;
  logic [1:0] primed;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      primed <= 2'b00;
    end else begin
      sync   <= {sync[0], rx};
      primed <= {primed[0], 1'b1};
    end
  end

  assign rx_s = sync[1];

  // Phase accumulator; tick is the carry out.
  logic [AccW-1:0] acc;
  logic [SumW-1:0] acc_sum;
  logic            tick;

  assign acc_sum = {1'b0, acc} + Inc;
  assign tick    = acc_sum[AccW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_sum[AccW-1:0];
  end

  // Framing FSM.
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [ScntW-1:0] scnt, scnt_n;
  logic [2:0]       bcnt, bcnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             push_c, ferr_c;
  logic             push_q, ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      bcnt      <= bcnt_n;
      shreg     <= shreg_n;
      push_q    <= push_c;
      ferr_q    <= ferr_c;
      frame_err <= ferr_q;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    if (tick) begin
      case (state)
        WAIT_IDLE: begin
          if (rx_s && primed[1]) state_n = IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            scnt_n  = '0;
          end
        end
        START: begin
          if (scnt == MidCnt) begin
            scnt_n = '0;
            bcnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + ScntW'(1);
          end
        end
        DATA: begin
          if (scnt == LastCnt) begin
            scnt_n  = '0;
            shreg_n = {rx_s, shreg[7:1]};
            bcnt_n  = bcnt + 3'd1;
            if (bcnt == 3'd7) state_n = STOP;
          end else begin
            scnt_n = scnt + ScntW'(1);
          end
        end
        STOP: begin
          if (scnt == LastCnt) begin
            scnt_n = '0;
            if (rx_s) begin
              push_c  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_c  = 1'b1;
              state_n = WAIT_IDLE;
            end
          end else begin
            scnt_n = scnt + ScntW'(1);
          end
        end
        default: state_n = WAIT_IDLE;
      endcase
    end
  end

  // Show-ahead FIFO; rx_data is registered with the head that will be valid next cycle.
  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wptr, rptr, rptr_inc;
  logic            pop, full, wr, ovf;
  logic [CntW-1:0] count_left, count_n;
  logic [7:0]      head_n;

  assign pop        = rd_en && rx_avail;
  assign full       = (fifo_count == CntW'(FifoDepth));
  assign wr         = push_q && (!full || pop);
  assign ovf        = push_q && full && !pop;
  assign rptr_inc   = rptr + PtrW'(1);
  assign count_left = fifo_count - CntW'(pop);
  assign count_n    = count_left + CntW'(wr);

  always_comb begin
    head_n = rx_data;
    if (wr && (count_left == '0)) head_n = shreg;
    else if (pop)                 head_n = mem[rptr_inc];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rx_avail   <= 1'b0;
      rx_data    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + PtrW'(1);
      if (pop) rptr <= rptr_inc;
      fifo_count <= count_n;
      rx_avail   <= (count_n != '0);
      rx_data    <= head_n;
      if (ovf)      overrun <= 1'b1;
      else if (pop) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, fixed baud set by parameters. It pairs with the existing transmitter on the same serial link to give the Z80 an incoming byte path. The block oversamples the line with a fractional tick generator and frames characters with a state machine. Received bytes go into a small show-ahead FIFO that the CPU-side I/O decode polls and pops.

## Interface
- `ClkFrequency`, default 1_000_000: clk frequency in Hz.
- `Baud`, default 115200: line bit rate.
- `Oversampling`, default 8: ticks per bit. Power of two, ≥4. Requires `ClkFrequency ≥ Baud*Oversampling`.
- `FifoDepth`, default 4: FIFO entries. Power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to clk.
- `rd_en`  in  1  pops the FIFO head when `rx_avail`=1; ignored when empty.
- `rx_data`  out  8  FIFO head (show-ahead); valid while `rx_avail`=1.
- `rx_avail`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FifoDepth)+1  number of bytes held.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.

One clock; reset is asynchronous and active-low.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Tick generator:** phase accumulator, free-running from reset.
  - `Inc = round(Baud*Oversampling*2^W / ClkFrequency)`, where `W = clog2(ClkFrequency/(Baud*Oversampling)) + 8`.
  - `tick` is the carry out of `acc + Inc`, so it is high for one clk.
  - When `ClkFrequency == Baud*Oversampling`, `tick` is high every cycle.
- **FSM states:** WAIT_IDLE, IDLE, START, DATA, STOP. A sample counter `scnt` (0..Oversampling-1) and a bit counter `bcnt` (0..7) only advance on `tick`.
  - WAIT_IDLE is the reset state. On a tick with `rx_s`=1, go to IDLE.
  - IDLE: on a tick with `rx_s`=0, go to START with `scnt`=0.
  - START: on the tick where `scnt` reaches Oversampling/2-1 (mid start bit):
    - `rx_s`=0: go to DATA, `scnt`=0, `bcnt`=0.
    - `rx_s`=1: glitch, return to IDLE. Nothing is reported.
  - DATA: sample when `scnt` reaches Oversampling-1. The sampled bit shifts into bit 7 of the shift register, shifting right. Increment `bcnt`. After bit 7, go to STOP.
  - STOP: sample one bit period after bit 7.
    - `rx_s`=1: push the byte to the FIFO, go to IDLE.
    - `rx_s`=0: pulse `frame_err`, drop the byte, go to WAIT_IDLE.
  - One stop bit is checked. A following start bit is accepted from the next tick onward.
- **FIFO:** circular buffer with write pointer, read pointer and count.
  - Push when full: byte dropped, `overrun` set to 1, `fifo_count` unchanged.
  - Push and valid pop in the same cycle: both take effect, count unchanged. This applies when full too, with no overrun.
  - `overrun` clears on any accepted pop, unless an overrunning push occurs in that same cycle.
  - Pointers wrap modulo FifoDepth.

## Timing
- Reset values: `rx_avail`=0, `fifo_count`=0, `rx_data`=0, `frame_err`=0, `overrun`=0. FSM in WAIT_IDLE, accumulator 0.
- Reset asserted mid-frame aborts the frame and clears the FIFO. After release, the line must be seen high before any start bit is accepted.
- `rx_data`, `rx_avail` and `fifo_count` update on the clk edge after the push or pop. `rd_en` is sampled on a rising edge, and the next head appears the following cycle.
- Latency in the tick-every-cycle configuration, with Oversampling=8 and `rx` falling before edge T:
  - start detect at T+2
  - start check at T+6
  - bit n sampled at T+14+8n
  - stop sampled at T+78
  - `rx_avail` (or the `frame_err` pulse) at T+79
- General latency: `rx_avail` rises 9.5 bit periods + ≤3 clk + 1 tick after the falling edge of the start bit.

## Test plan
- Params 921600/115200/8 (tick every clk), 8 clk per bit. Send 0xA5 → at T+79 `rx_avail`=1, `rx_data`=0xA5, `fifo_count`=1. Then `rd_en` for 1 cycle → `rx_avail`=0 next cycle.
- Low pulse of 3 clk on idle `rx` → no push and no `frame_err`. Then a valid 0x3C → 0x3C received.
- 0x55 with stop bit held 0, then line high → one `frame_err` pulse, FIFO empty. The next frame 0x01 is received correctly.
- Five back-to-back bytes 0x10..0x14 with no reads (FifoDepth=4) → `fifo_count`=4 and `overrun`=1. Pops return 0x10..0x13, and the first pop clears `overrun`.
- FIFO full, with `rd_en` asserted on the exact cycle of a new push → count stays 4, `overrun` stays 0, and byte order is preserved.
- Drop `rst_n` while bit 4 is being received, with `rx` held low through the release → no start is detected until `rx` goes high. The next full frame 0xC3 is received.
